force_array_ctrl: RTL and testbench

FORCE_ARRAY_CTRL -- requirements
Module: force_array_ctrl

---
 rtl/force_array_ctrl.sv | 93 +++++++++
 tb/tb_force_array_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/force_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : force_array_ctrl
//  Purpose  : Per-element force/hold overlay for an N x W data array. A rising
//             edge of en captures force_val into the selected elements and
//             marks them forced; forced elements present the held value on q
//             instead of d_in. Elements are released by a falling edge of en
//             (unless STICKY) or by a per-element release request.
//  Revision : 1.0 - initial release
// ============================================================================
module force_array_ctrl #(
  parameter int N      = 8,
  parameter int W      = 1,
  parameter int STICKY = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N-1:0]              sel,
  input  logic [N*W-1:0]            force_val,
  input  logic [N-1:0]              release_req,
  input  logic [N*W-1:0]            d_in,
  output logic [N*W-1:0]            q,
  output logic [N-1:0]              forced,
  output logic [$clog2(N+1)-1:0]    force_cnt
);

  localparam int   c_CNT_W  = $clog2(N+1);
  localparam logic c_STICKY = (STICKY != 0);

  logic               r_en_d;
  logic [N-1:0]       r_forced;
  logic [c_CNT_W-1:0] r_cnt;
  logic [W-1:0]       r_hold [N];

  logic               w_rise;
  logic               w_fall;
  logic [N-1:0]       w_cap;
  logic [N-1:0]       w_forced_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  assign w_rise = en & ~r_en_d;
  assign w_fall = ~en & r_en_d & ~c_STICKY;

  // A release request masks the capture so a coincident rise cannot touch hold.
  assign w_cap = sel & ~release_req & {N{w_rise}};

  // Next forced vector and its population count, so the count lands with it.
  always_comb begin
    w_forced_nxt = r_forced;
    if (w_fall) begin
      w_forced_nxt = '0;
    end
    w_forced_nxt = (w_forced_nxt | w_cap) & ~release_req;
    w_cnt_nxt = '0;
    for (int i = 0; i < N; i++) begin
      w_cnt_nxt = w_cnt_nxt + c_CNT_W'(w_forced_nxt[i]);
    end
  end

  // Edge-detect history, forced status and count. en_d tracks en through reset
  // so a level held across reset does not look like an edge afterwards.
  always_ff @(posedge clk) begin
    r_en_d <= en;
    if (rst) begin
      r_forced <= '0;
      r_cnt    <= '0;
    end else begin
      r_forced <= w_forced_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
      // Hold register for element gi: loaded only on a qualified capture.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_hold[gi] <= '0;
        end else if (w_cap[gi]) begin
          r_hold[gi] <= force_val[gi*W +: W];
        end
      end

      assign q[gi*W +: W] = r_forced[gi] ? r_hold[gi] : d_in[gi*W +: W];
    end
  endgenerate

  assign forced    = r_forced;
  assign force_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_force_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_force_array_ctrl
//  Purpose  : Self-checking bench for force_array_ctrl. Three instances:
//             N=8/W=4 non-sticky, N=8/W=4 sticky (same stimulus), N=1/W=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_force_array_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  sel = '0;
  logic [31:0] force_val = '0;
  logic [7:0]  release_req = '0;
  logic [31:0] d_in = '0;
  logic [31:0] q, q_s;
  logic [7:0]  forced, forced_s;
  logic [3:0]  cnt, cnt_s;

  logic sm_en = 1'b0, sm_sel = 1'b0, sm_fv = 1'b0, sm_rel = 1'b0, sm_d = 1'b0;
  logic sm_q, sm_forced, sm_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  force_array_ctrl #(.N(8), .W(4), .STICKY(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .force_val(force_val),
    .release_req(release_req), .d_in(d_in), .q(q), .forced(forced), .force_cnt(cnt));

  force_array_ctrl #(.N(8), .W(4), .STICKY(1)) u_sticky (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .force_val(force_val),
    .release_req(release_req), .d_in(d_in), .q(q_s), .forced(forced_s), .force_cnt(cnt_s));

  force_array_ctrl #(.N(1), .W(1), .STICKY(0)) u_small (
    .clk(clk), .rst(rst), .en(sm_en), .sel(sm_sel), .force_val(sm_fv),
    .release_req(sm_rel), .d_in(sm_d), .q(sm_q), .forced(sm_forced), .force_cnt(sm_cnt));

  typedef struct {
    string       tag;
    logic [7:0]  f;
    logic [3:0]  c;
    logic [31:0] qv;
    logic [7:0]  fs;
    logic [3:0]  cs;
    logic [31:0] qs;
    logic        sf;
    logic        sc;
    logic        sq;
  } exp_t;

  exp_t sb[$];

  // Reference state: index 0 = non-sticky, 1 = sticky.
  logic       m_en_d = 1'b0;
  logic [7:0] m_forced [2];
  logic [3:0] m_hold [2][8];
  logic       ms_en_d = 1'b0;
  logic       ms_forced = 1'b0;
  logic       ms_hold = 1'b0;

  task automatic step(input string tag);
    exp_t e;
    logic rise, fall, srise, sfall;
    exp_t got;
    rise  = en & ~m_en_d;
    fall  = ~en & m_en_d;
    srise = sm_en & ~ms_en_d;
    sfall = ~sm_en & ms_en_d;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_forced[k] = '0;
        for (int j = 0; j < 8; j++) m_hold[k][j] = '0;
      end else begin
        if (fall && k == 0) m_forced[k] = '0;
        for (int j = 0; j < 8; j++) begin
          if (release_req[j]) m_forced[k][j] = 1'b0;
          else if (rise && sel[j]) begin
            m_forced[k][j] = 1'b1;
            m_hold[k][j]   = force_val[j*4 +: 4];
          end
        end
      end
    end
    m_en_d = en;
    if (rst) begin
      ms_forced = 1'b0;
      ms_hold   = 1'b0;
    end else begin
      if (sfall) ms_forced = 1'b0;
      if (sm_rel) ms_forced = 1'b0;
      else if (srise && sm_sel) begin
        ms_forced = 1'b1;
        ms_hold   = sm_fv;
      end
    end
    ms_en_d = sm_en;
    e.tag = tag;
    e.f   = m_forced[0];
    e.fs  = m_forced[1];
    e.c   = 4'($countones(m_forced[0]));
    e.cs  = 4'($countones(m_forced[1]));
    for (int j = 0; j < 8; j++) begin
      e.qv[j*4 +: 4] = m_forced[0][j] ? m_hold[0][j] : d_in[j*4 +: 4];
      e.qs[j*4 +: 4] = m_forced[1][j] ? m_hold[1][j] : d_in[j*4 +: 4];
    end
    e.sf = ms_forced;
    e.sc = ms_forced;
    e.sq = ms_forced ? ms_hold : sm_d;
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    total += 9;
    if (forced !== got.f) begin bad++; $display("FAIL %s forced got=%h exp=%h", got.tag, forced, got.f); end
    if (cnt !== got.c) begin bad++; $display("FAIL %s force_cnt got=%0d exp=%0d", got.tag, cnt, got.c); end
    if (q !== got.qv) begin bad++; $display("FAIL %s q got=%h exp=%h", got.tag, q, got.qv); end
    if (forced_s !== got.fs) begin bad++; $display("FAIL %s sticky forced got=%h exp=%h", got.tag, forced_s, got.fs); end
    if (cnt_s !== got.cs) begin bad++; $display("FAIL %s sticky force_cnt got=%0d exp=%0d", got.tag, cnt_s, got.cs); end
    if (q_s !== got.qs) begin bad++; $display("FAIL %s sticky q got=%h exp=%h", got.tag, q_s, got.qs); end
    if (sm_forced !== got.sf) begin bad++; $display("FAIL %s small forced got=%b exp=%b", got.tag, sm_forced, got.sf); end
    if (sm_cnt !== got.sc) begin bad++; $display("FAIL %s small force_cnt got=%b exp=%b", got.tag, sm_cnt, got.sc); end
    if (sm_q !== got.sq) begin bad++; $display("FAIL %s small q got=%b exp=%b", got.tag, sm_q, got.sq); end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    d_in = 32'h1234_5678;
    step("reset0");
    step("reset1");
    total++;
    if (q !== 32'h1234_5678 || forced !== 8'h00 || cnt !== 4'd0) begin
      bad++; $display("FAIL reset_state q=%h forced=%h cnt=%0d exp q=12345678 forced=00 cnt=0", q, forced, cnt);
    end
    rst = 1'b0;
    step("post_reset");
  endtask

  task automatic test_basic();
    sel       = 8'h05;
    force_val = 32'h0000_030A;
    en        = 1'b1;
    step("basic_rise");
    total++;
    if (forced !== 8'h05 || cnt !== 4'd2 || q !== 32'h1234_537A) begin
      bad++; $display("FAIL basic_force forced=%h cnt=%0d q=%h exp 05/2/1234537a", forced, cnt, q);
    end
    force_val = 32'hFFFF_FFFF;
    step("basic_frozen");
    total++;
    if (q !== 32'h1234_537A) begin bad++; $display("FAIL basic_frozen q=%h exp=1234537a", q); end
    en = 1'b0;
    step("basic_fall");
    total++;
    if (forced !== 8'h00 || q !== d_in || forced_s !== 8'h05) begin
      bad++; $display("FAIL basic_fall forced=%h q=%h sticky=%h exp 00/%h/05", forced, q, forced_s, d_in);
    end
  endtask

  task automatic test_release_prio();
    sel         = 8'h03;
    release_req = 8'h01;
    force_val   = 32'h0000_00BC;
    en          = 1'b1;
    step("prio_rise");
    total++;
    if (forced !== 8'h02 || q[3:0] !== d_in[3:0]) begin
      bad++; $display("FAIL release_prio forced=%h q0=%h exp 02/%h", forced, q[3:0], d_in[3:0]);
    end
    release_req = 8'h00;
  endtask

  task automatic test_recapture();
    en = 1'b0;
    step("recap_fall");
    sel       = 8'h08;
    force_val = 32'h0000_5000;
    en        = 1'b1;
    step("recap_rise5");
    total++;
    if (q[15:12] !== 4'h5) begin bad++; $display("FAIL recap_5 q3=%h exp=5", q[15:12]); end
    en = 1'b0;
    step("recap_gap");
    total++;
    if (q[15:12] !== d_in[15:12]) begin bad++; $display("FAIL recap_gap q3=%h exp=%h", q[15:12], d_in[15:12]); end
    force_val = 32'h0000_9000;
    en        = 1'b1;
    step("recap_rise9");
    total++;
    if (q[15:12] !== 4'h9 || q_s[15:12] !== 4'h9 || forced_s[3] !== 1'b1) begin
      bad++; $display("FAIL recap_9 q3=%h sticky_q3=%h exp 9/9", q[15:12], q_s[15:12]);
    end
  endtask

  task automatic test_sticky();
    en        = 1'b0;
    step("sticky_pre");
    sel       = 8'hFF;
    force_val = 32'h89AB_CDEF;
    en        = 1'b1;
    step("sticky_rise");
    en = 1'b0;
    step("sticky_fall");
    total++;
    if (forced_s !== 8'hFF) begin bad++; $display("FAIL sticky_hold forced=%h exp=ff", forced_s); end
    release_req = 8'h10;
    step("sticky_rel");
    total++;
    if (forced_s !== 8'hEF || cnt_s !== 4'd7) begin
      bad++; $display("FAIL sticky_release forced=%h cnt=%0d exp ef/7", forced_s, cnt_s);
    end
    release_req = 8'h00;
  endtask

  task automatic test_rst_en_high();
    en = 1'b1;
    step("rsthi_rise");
    rst = 1'b1;
    step("rsthi_rst");
    total++;
    if (forced !== 8'h00 || cnt !== 4'd0 || forced_s !== 8'h00) begin
      bad++; $display("FAIL rst_clear forced=%h cnt=%0d sticky=%h exp 00/0/00", forced, cnt, forced_s);
    end
    rst = 1'b0;
    step("rsthi_post");
    total++;
    if (forced !== 8'h00 || forced_s !== 8'h00) begin
      bad++; $display("FAIL rst_no_rise forced=%h sticky=%h exp 00", forced, forced_s);
    end
  endtask

  task automatic test_small();
    sm_d = 1'b0; sm_sel = 1'b1; sm_fv = 1'b1; sm_en = 1'b1;
    step("small_rise");
    total++;
    if (sm_q !== 1'b1 || sm_cnt !== 1'b1) begin bad++; $display("FAIL small_force q=%b cnt=%b exp 1/1", sm_q, sm_cnt); end
    sm_fv = 1'b0;
    step("small_frozen");
    sm_en = 1'b0;
    step("small_fall");
    total++;
    if (sm_q !== 1'b0 || sm_forced !== 1'b0) begin bad++; $display("FAIL small_fall q=%b forced=%b exp 0/0", sm_q, sm_forced); end
    sm_en = 1'b1; sm_rel = 1'b1; sm_fv = 1'b1;
    step("small_prio");
    total++;
    if (sm_forced !== 1'b0) begin bad++; $display("FAIL small_prio forced=%b exp 0", sm_forced); end
    sm_rel = 1'b0; sm_en = 1'b0;
    step("small_idle");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      en          = 1'($urandom_range(0, 1));
      sel         = 8'($urandom);
      force_val   = $urandom;
      d_in        = $urandom;
      release_req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      rst         = ($urandom_range(0, 19) == 0);
      sm_en       = 1'($urandom_range(0, 1));
      sm_sel      = 1'($urandom_range(0, 1));
      sm_fv       = 1'($urandom_range(0, 1));
      sm_d        = 1'($urandom_range(0, 1));
      sm_rel      = ($urandom_range(0, 3) == 0);
      step("rand");
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_release_prio();
    test_recapture();
    test_sticky();
    test_rst_en_high();
    test_small();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
